fb_mono_scanout: RTL and testbench
==================================

Name: fb_mono_scanout

Overview:
- Monochrome framebuffer scan-out engine. Generates 1024x768 video timing.
- Fetches 32-bit framebuffer words through a request/acknowledge port from the memory side, buffers them in a 4-word FIFO, and serializes them into pixels.
- Drives the 2-bit RGB, hsync, vsync and blank inputs of the DVI encoder stage in the pixel clock domain.

Parameters:
- C_resolution_x, 1024, active pixels per line (multiple of 32)
- C_hsync_front_porch, 24, pixels
- C_hsync_pulse, 136, pixels
- C_hsync_back_porch, 160, pixels
- C_resolution_y, 768, active lines
- C_vsync_front_porch, 3, lines
- C_vsync_pulse, 6, lines
- C_vsync_back_porch, 29, lines
- C_addr_bits, 15, width of word index (must hold x*y/32 - 1)
- C_invert, 0, 1 = pixel bit 0 displays white

Ports:
- clk_pixel  in  1  pixel clock (65 MHz); sole clock
- reset  in  1  asynchronous, active-high
- fetch_req  out  1  word request; held until fetch_ack
- fetch_addr  out  C_addr_bits  word index within frame, stable while fetch_req=1
- fetch_ack  in  1  one-cycle strobe; fetch_data valid same cycle
- fetch_data  in  32  framebuffer word; bit 0 = leftmost pixel
- vga_r, vga_g, vga_b  out  2 each  pixel colour
- vga_hsync, vga_vsync  out  1 each  active-high sync pulses
- vga_blank  out  1  1 outside active area
- underrun  out  1  sticky; set when a word is needed and the FIFO is empty

Behaviour:
- Reset (async) values:
  - h=v=0, FIFO empty, fetch_addr=0, fetch_req=0, underrun=0.
  - vga_r/g/b=0, vga_hsync=0, vga_vsync=0, vga_blank=1.
- Counters:
  - H_TOTAL = sum of the four horizontal parameters = 1344; V_TOTAL = 806.
  - h wraps at H_TOTAL-1 to 0, and v increments on that wrap.
  - v wraps at V_TOTAL-1 to 0.
- Region decode:
  - active = h<C_resolution_x && v<C_resolution_y.
  - hsync when C_resolution_x+FP <= h < C_resolution_x+FP+PULSE (analogous for vsync on v).
- Output registration: all video outputs are registered with exactly 1 cycle of latency from the counter state. Sync, blank and pixel data stay mutually aligned.
- Pixel shifter:
  - At each active pixel with h[4:0]==0, pop one FIFO word into a 32-bit shift register; output bit 0 as the current pixel.
  - Shift right on each following active pixel.
  - Pixel bit p maps to vga_r/g/b = {p^C_invert, p^C_invert} on all three channels. Blanked pixels output 0.
- Underrun:
  - A pop is required but the FIFO is empty: load 0 (black after invert), set underrun, keep the pixel position.
  - underrun clears only on reset.
- Fetch FSM:
  - States IDLE, REQ, DONE. At most one request outstanding.
  - IDLE -> REQ when words_fetched < C_resolution_x*C_resolution_y/32 and FIFO count + 0 outstanding <= 3.
  - REQ: fetch_req=1. On fetch_ack, push fetch_data, increment fetch_addr, drop fetch_req next cycle, then go to IDLE.
  - DONE when all 24576 words have been fetched; no requests until frame restart.
- Frame restart:
  - At h==0, v==C_resolution_y (first vblank line): FIFO flush, fetch_addr=0, state=IDLE. Prefetch of the next frame starts immediately.
  - A fetch_ack arriving in that same cycle is discarded.
- FIFO:
  - 4 x 32 with depth counter 0..4.
  - Push and pop in the same cycle keep the count unchanged.
  - A push while full cannot occur by construction; an assertion flags it.
- fetch_ack while fetch_req=0 is ignored.
- Reset asserted mid-frame or mid-request aborts immediately to reset values. The memory side must tolerate a dropped request.

Test Plan:
- Reset, fetch_ack tied to respond 2 cycles after each fetch_req, data = word index -> first active line pixel 0..31 equals bits of word 0 (all black). Pixel 32 equals bit 0 of word 1 (=1, white 2'b11). underrun stays 0 over a full frame.
- Count cycles -> hsync high for 136 cycles starting 1 cycle after h=1048. vsync high for 6 lines starting at line 771. Period 1344x806.
- Data 32'h0000_0001 for all words, C_invert=0 -> one white pixel every 32. blank=1 at h>=1024 outputs 0 colour.
- Hold fetch_ack low after 4 words -> at h=128 of line 0, FIFO empty; underrun=1 and black output. Resuming acks restores data; underrun stays 1.
- Observe fetch_addr -> reaches 24575, then no fetch_req until h=0, v=768. Then fetch_addr=0 and 4 words prefetched before line 0.
- Assert reset for 3 cycles mid-line during an outstanding request -> fetch_req=0, blank=1 within the reset cycle. Next frame output is correct.

Source files
------------

// File: rtl/fb_mono_scanout.sv
// Monochrome framebuffer scan-out: video timing, word fetch into a 4-deep FIFO,
// and a 32-bit pixel serializer feeding the DVI encoder stage.
module fb_mono_scanout #(
    parameter int C_resolution_x      = 1024,
    parameter int C_hsync_front_porch = 24,
    parameter int C_hsync_pulse       = 136,
    parameter int C_hsync_back_porch  = 160,
    parameter int C_resolution_y      = 768,
    parameter int C_vsync_front_porch = 3,
    parameter int C_vsync_pulse       = 6,
    parameter int C_vsync_back_porch  = 29,
    parameter int C_addr_bits         = 15,
    parameter bit C_invert            = 1'b0
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    output logic                   fetch_req,
    output logic [C_addr_bits-1:0] fetch_addr,
    input  logic                   fetch_ack,
    input  logic [31:0]            fetch_data,
    output logic [1:0]             vga_r,
    output logic [1:0]             vga_g,
    output logic [1:0]             vga_b,
    output logic                   vga_hsync,
    output logic                   vga_vsync,
    output logic                   vga_blank,
    output logic                   underrun
);
    localparam int H_TOTAL = C_resolution_x + C_hsync_front_porch + C_hsync_pulse + C_hsync_back_porch;
    localparam int V_TOTAL = C_resolution_y + C_vsync_front_porch + C_vsync_pulse + C_vsync_back_porch;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int WORDS   = C_resolution_x * C_resolution_y / 32;

    localparam logic [HW-1:0] H_ACT  = HW'(C_resolution_x);
    localparam logic [HW-1:0] HS_BEG = HW'(C_resolution_x + C_hsync_front_porch);
    localparam logic [HW-1:0] HS_END = HW'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(C_resolution_y);
    localparam logic [VW-1:0] VS_BEG = VW'(C_resolution_y + C_vsync_front_porch);
    localparam logic [VW-1:0] VS_END = VW'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [C_addr_bits-1:0] ADDR_LAST = C_addr_bits'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} fetch_state_t;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          active, hs, vs, restart, pop_slot;

    // ---------------- timing counters ----------------
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    assign active   = (h < H_ACT) && (v < V_ACT);
    assign hs       = (h >= HS_BEG) && (h < HS_END);
    assign vs       = (v >= VS_BEG) && (v < VS_END);
    assign restart  = (h == '0) && (v == V_ACT);
    assign pop_slot = active && (h[4:0] == 5'd0);

    // ---------------- word FIFO ----------------
    logic [31:0] fifo_mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        push, pop, fifo_empty;

    assign fifo_empty = (count == 3'd0);
    // Acks landing on the restart cycle belong to the old frame and are dropped.
    assign push = fetch_req && fetch_ack && !restart;
    assign pop  = pop_slot && !fifo_empty;

    always_ff @(posedge clk_pixel) begin
        if (push) fifo_mem[wr_ptr] <= fetch_data;
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (restart) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + 3'(push) - 3'(pop);
        end
    end

    assert property (@(posedge clk_pixel) disable iff (reset) !(push && count == 3'd4));

    // ---------------- pixel shifter ----------------
    logic [31:0] shreg, shreg_nxt, word;
    logic        pix;

    always_comb begin
        shreg_nxt = shreg;
        pix       = shreg[0];
        // An empty FIFO loads a word that renders black regardless of inversion.
        word      = fifo_empty ? {32{C_invert}} : fifo_mem[rd_ptr];
        if (pop_slot) begin
            pix       = word[0];
            shreg_nxt = word >> 1;
        end else if (active) begin
            shreg_nxt = shreg >> 1;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            vga_hsync <= 1'b0;
            vga_vsync <= 1'b0;
            vga_blank <= 1'b1;
            underrun  <= 1'b0;
        end else begin
            shreg     <= shreg_nxt;
            vga_r     <= active ? {2{pix ^ C_invert}} : 2'b00;
            vga_g     <= active ? {2{pix ^ C_invert}} : 2'b00;
            vga_b     <= active ? {2{pix ^ C_invert}} : 2'b00;
            vga_hsync <= hs;
            vga_vsync <= vs;
            vga_blank <= !active;
            underrun  <= underrun | (pop_slot && fifo_empty);
        end
    end

    // ---------------- fetch FSM ----------------
    fetch_state_t state, state_nxt;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count <= 3'd3) state_nxt = REQ;
            REQ:     if (fetch_ack) state_nxt = (fetch_addr == ADDR_LAST) ? DONE : IDLE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (restart) state_nxt = IDLE;
    end

    assign fetch_req = (state == REQ);

    // The address saturates at the last word; DONE stops further requests.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset)
            fetch_addr <= '0;
        else if (restart)
            fetch_addr <= '0;
        else if (fetch_req && fetch_ack && fetch_addr != ADDR_LAST)
            fetch_addr <= fetch_addr + 1'b1;
    end

endmodule

// File: tb/tb_fb_mono_scanout.sv
// Scoreboarded bench for fb_mono_scanout on a reduced raster, with a
// queue-based reference model of the frame, FIFO and fetch handshake.
module tb_fb_mono_scanout;
    localparam int RX = 128, HFP = 8, HP = 16, HBP = 16;
    localparam int RY = 6,   VFP = 1, VP = 2,  VBP = 3;
    localparam int AB = 5;
    localparam bit INV = 1'b0;
    localparam int HT = RX + HFP + HP + HBP;
    localparam int VT = RY + VFP + VP + VBP;
    localparam int FRAME = HT * VT;
    localparam int WORDS = RX * RY / 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_req;
    logic [AB-1:0] fetch_addr;
    logic          fetch_ack = 1'b0;
    logic [31:0]   fetch_data = '0;
    logic [1:0]    vga_r, vga_g, vga_b;
    logic          vga_hsync, vga_vsync, vga_blank, underrun;

    fb_mono_scanout #(
        .C_resolution_x(RX), .C_hsync_front_porch(HFP), .C_hsync_pulse(HP), .C_hsync_back_porch(HBP),
        .C_resolution_y(RY), .C_vsync_front_porch(VFP), .C_vsync_pulse(VP), .C_vsync_back_porch(VBP),
        .C_addr_bits(AB), .C_invert(INV)
    ) dut (
        .clk_pixel(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] rgb;
        logic       hs, vs, blank, und;
    } vid_t;

    int          checks = 0, errors = 0;
    logic [31:0] mem [WORDS];
    vid_t        exp_q [$];
    logic [31:0] fifo_m [$];
    int          n = 0, exp_addr = 0;
    logic [31:0] cur = '0;
    bit          cur_ok = 0, und_m = 0, saw_done = 0;
    bit          stall = 0, rnd = 0, spurious = 0;

    function automatic void check(string nm, longint act, longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endfunction

    // Reference model: what the display must show after the coming edge.
    always @(negedge clk) begin
        if (reset) begin
            n = 0; exp_addr = 0; cur_ok = 0; und_m = 0;
            fifo_m.delete(); exp_q.delete();
        end else begin
            int  h, v, px;
            bit  act, pix;
            h   = n % HT;
            v   = (n / HT) % VT;
            act = (h < RX) && (v < RY);
            if (fetch_req) begin
                check("req_fifo_room", fifo_m.size() <= 3, 1);
                check("req_after_done", exp_addr < WORDS, 1);
            end
            if (n > 0 && h == 0 && v == 0) check("prefetch_depth", fifo_m.size(), 4);
            if (h == 0 && v == RY) begin
                fifo_m.delete();
                exp_addr = 0;
            end else begin
                if (act && h % 32 == 0) begin
                    if (fifo_m.size() > 0) begin
                        cur = fifo_m.pop_front(); cur_ok = 1;
                    end else begin
                        cur_ok = 0; und_m = 1;
                    end
                end
                if (fetch_req && fetch_ack) begin
                    check("fetch_addr", fetch_addr, exp_addr);
                    if (exp_addr < WORDS) fifo_m.push_back(mem[exp_addr]);
                    exp_addr++;
                    if (exp_addr == WORDS) saw_done = 1;
                end
            end
            px  = h % 32;
            pix = act && cur_ok && (cur[px] ^ INV);
            exp_q.push_back({{6{pix}},
                             (h >= RX + HFP) && (h < RX + HFP + HP),
                             (v >= RY + VFP) && (v < RY + VFP + VP),
                             !act, und_m});
            n++;
        end
    end

    // Monitor: every pixel clock presents one output sample.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (exp_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL video_sample: got output with no expectation queued (t=%0t)", $time);
            end else begin
                vid_t e;
                e = exp_q.pop_front();
                check("video", {vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank, underrun}, e);
            end
        end
    end

    // Memory side: acks after a delay while fetch_req is held.
    int wcnt = 0, dly = 2;
    always @(posedge clk) begin
        #2;
        if (reset) begin
            fetch_ack = 0; wcnt = 0;
        end else if (fetch_ack) begin
            fetch_ack = 0;
        end else if (fetch_req) begin
            if (!stall) wcnt++;
            if (wcnt >= dly) begin
                fetch_ack  = 1;
                fetch_data = mem[fetch_addr];
                wcnt = 0;
                dly  = rnd ? int'($urandom_range(1, 5)) : 2;
            end
        end else begin
            wcnt = 0;
            if (spurious && $urandom_range(0, 7) == 0) begin
                fetch_ack  = 1;
                fetch_data = $urandom;
            end
        end
    end

    task automatic hold_reset();
        @(posedge clk); #3 reset = 1;
        repeat (3) @(posedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk); #3 reset = 0;
    endtask

    task automatic run(int cycles);
        repeat (cycles) @(posedge clk);
    endtask

    initial begin
        int k;
        for (int i = 0; i < WORDS; i++) mem[i] = i;
        repeat (3) @(posedge clk);
        #4;
        check("rst_fetch_req", fetch_req, 0);
        check("rst_fetch_addr", fetch_addr, 0);
        check("rst_underrun", underrun, 0);
        check("rst_blank", vga_blank, 1);
        check("rst_hsync", vga_hsync, 0);
        check("rst_vsync", vga_vsync, 0);
        check("rst_rgb", {vga_r, vga_g, vga_b}, 0);

        // Frames with word-index data and a fixed 2-cycle ack latency.
        release_reset();
        run(2 * FRAME + 50);
        check("addr_reached_last", saw_done, 1);

        // Reset mid-line while a request is outstanding.
        k = 0;
        do begin
            @(posedge clk); #3; k++;
        end while (!(fetch_req && (n % HT) > 20 && (n % HT) < RX) && k < 5000);
        check("wait_req_midline", k < 5000, 1);
        reset = 1;
        #1;
        check("midrst_fetch_req", fetch_req, 0);
        check("midrst_blank", vga_blank, 1);
        check("midrst_underrun", underrun, 0);
        check("midrst_rgb", {vga_r, vga_g, vga_b}, 0);
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h0000_0001;
        repeat (3) @(posedge clk);
        release_reset();
        run(2 * FRAME + 50);

        // Random data, random latency, stray acks with no request.
        hold_reset();
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        rnd = 1; spurious = 1;
        release_reset();
        run(2 * FRAME + 50);

        // Memory stalls after four words, then resumes.
        hold_reset();
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        rnd = 0; spurious = 0;
        release_reset();
        k = 0;
        while (exp_addr < 4 && k < 2000) begin
            @(posedge clk); k++;
        end
        check("wait_four_words", k < 2000, 1);
        stall = 1;
        run(2 * HT);
        check("stall_underrun", underrun, 1);
        stall = 0;
        run(2 * FRAME + 50);
        check("stall_underrun_sticky", underrun, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
